// File: rtl/scoreboard_pkg.sv
// Shared match types: FSM states, winner codes, pending-event record and score limits.
package scoreboard_pkg;

  typedef enum logic [2:0] {
    ST_PLAY   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WON    = 3'd2,
    ST_CLEAR  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Source of the single event granted in PLAY.
  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_PEND1 = 3'd1,
    SRC_PEND2 = 3'd2,
    SRC_NEW1  = 3'd3,
    SRC_NEW2  = 3'd4
  } src_e;

  // One-deep per-player event record: valid flag plus direction.
  typedef struct packed {
    logic valid;
    logic up;
  } pend_t;

  localparam logic [6:0] SCORE_MAX = 7'd99;
  localparam logic [6:0] SCORE_MIN = 7'd0;

  // True when the event would not push the counter past its limits.
  function automatic logic can_apply(input logic [6:0] score, input logic is_up);
    return is_up ? (score != SCORE_MAX) : (score != SCORE_MIN);
  endfunction

  // Win test widened to 8 bits so other + margin cannot wrap.
  function automatic logic wins(input logic [6:0] own, input logic [6:0] other,
                                input logic [7:0] min_score, input logic [7:0] margin);
    logic [7:0] own_w;
    logic [7:0] need_w;
    own_w  = {1'b0, own};
    need_w = {1'b0, other} + margin;
    return (own_w >= min_score) && (own_w >= need_w);
  endfunction

endpackage

// File: rtl/match_timer.sv
// Blink and hold timing for the WON state: free-running while enabled, zeroed by clear.
module match_timer #(
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned HOLD_MS  = 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic blink_toggle_o,
  output logic hold_expired_o
);

  localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int unsigned HW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);

  logic [BW-1:0] blink_q, blink_d;
  logic [HW-1:0] hold_q, hold_d;

  assign blink_toggle_o = en_i & ~clr_i & (blink_q == BLINK_LAST);
  assign hold_expired_o = en_i & ~clr_i & (hold_q == HOLD_LAST);

  // Next counter values: blink wraps each half-period, hold saturates at its last cycle.
  always_comb begin
    blink_d = blink_q;
    hold_d  = hold_q;
    if (clr_i) begin
      blink_d = '0;
      hold_d  = '0;
    end else if (en_i) begin
      blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
      hold_d  = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_q <= '0;
      hold_q  <= '0;
    end else begin
      blink_q <= blink_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Match controller: gates score events, detects a win, blinks the display and restarts games.
module match_controller
  import scoreboard_pkg::*;
#(
  parameter int unsigned WIN_SCORE  = 21,
  parameter int unsigned WIN_MARGIN = 2,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned HOLD_MS    = 10000
) (
  input  logic       clk_1khz_i,
  input  logic       rst_ni,
  input  logic       up_p1_i,
  input  logic       down_p1_i,
  input  logic       up_p2_i,
  input  logic       down_p2_i,
  input  logic [6:0] score_p1_i,
  input  logic [6:0] score_p2_i,
  input  logic       new_game_i,
  output logic       up_p1_o,
  output logic       down_p1_o,
  output logic       up_p2_o,
  output logic       down_p2_o,
  output logic       score_clr_o,
  output logic [1:0] winner_o,
  output logic       blank_o,
  output logic [2:0] state_o
);

  localparam logic [7:0] WIN_SCORE_W  = 8'(WIN_SCORE);
  localparam logic [7:0] WIN_MARGIN_W = 8'(WIN_MARGIN);

  state_e  state_q, state_d;
  logic    settle_q, settle_d;
  pend_t   pend1_q, pend1_d, pend2_q, pend2_d;
  winner_e winner_q, winner_d;
  logic    blank_q, blank_d;
  logic    clr_q, clr_d;
  logic    up1_q, up1_d, dn1_q, dn1_d, up2_q, up2_d, dn2_q, dn2_d;

  pend_t   new1, new2;
  logic    pend1_ok, pend2_ok;
  logic    p1_wins, p2_wins, undo;
  src_e    src;
  logic    src_up;
  logic    blink_toggle, hold_expired;

  // Incoming events after up-over-down resolution and saturation filtering.
  always_comb begin
    new1.up    = up_p1_i & can_apply(score_p1_i, 1'b1);
    new1.valid = new1.up | (down_p1_i & ~up_p1_i & can_apply(score_p1_i, 1'b0));
    new2.up    = up_p2_i & can_apply(score_p2_i, 1'b1);
    new2.valid = new2.up | (down_p2_i & ~up_p2_i & can_apply(score_p2_i, 1'b0));
  end

  assign pend1_ok = pend1_q.valid & can_apply(score_p1_i, pend1_q.up);
  assign pend2_ok = pend2_q.valid & can_apply(score_p2_i, pend2_q.up);
  assign p1_wins  = wins(score_p1_i, score_p2_i, WIN_SCORE_W, WIN_MARGIN_W);
  assign p2_wins  = wins(score_p2_i, score_p1_i, WIN_SCORE_W, WIN_MARGIN_W);
  assign undo     = ((winner_q == WIN_P1) & new1.valid & ~new1.up) |
                    ((winner_q == WIN_P2) & new2.valid & ~new2.up);

  // Arbitration for PLAY: latched events drain before new ones, P1 ahead of P2 at each level.
  always_comb begin
    src    = SRC_NONE;
    src_up = 1'b0;
    if (pend1_ok) begin
      src    = SRC_PEND1;
      src_up = pend1_q.up;
    end else if (pend2_ok) begin
      src    = SRC_PEND2;
      src_up = pend2_q.up;
    end else if (new1.valid) begin
      src    = SRC_NEW1;
      src_up = new1.up;
    end else if (new2.valid) begin
      src    = SRC_NEW2;
      src_up = new2.up;
    end
  end

  match_timer #(
    .BLINK_MS (BLINK_MS),
    .HOLD_MS  (HOLD_MS)
  ) u_timer (
    .clk_i          (clk_1khz_i),
    .rst_ni         (rst_ni),
    .en_i           (state_q == ST_WON),
    .clr_i          (state_q != ST_WON),
    .blink_toggle_o (blink_toggle),
    .hold_expired_o (hold_expired)
  );

  // State register, including the SETTLE second-cycle flag.
  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_PLAY;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic; a new-game request overrides everything.
  always_comb begin
    state_d  = state_q;
    settle_d = 1'b0;
    if (new_game_i) begin
      state_d = ST_CLEAR;
    end else begin
      unique case (state_q)
        ST_PLAY:   if (src != SRC_NONE) state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (!settle_q)               settle_d = 1'b1;
          else if (p1_wins || p2_wins) state_d  = ST_WON;
          else                         state_d  = ST_PLAY;
        end
        ST_WON: begin
          if (undo)              state_d = ST_SETTLE;
          else if (hold_expired) state_d = ST_CLEAR;
        end
        ST_CLEAR:  state_d = ST_PLAY;
        default:   state_d = ST_PLAY;
      endcase
    end
  end

  // Output and pending-latch next values; every output leaves through a register.
  always_comb begin
    up1_d    = 1'b0;
    dn1_d    = 1'b0;
    up2_d    = 1'b0;
    dn2_d    = 1'b0;
    clr_d    = 1'b0;
    winner_d = winner_q;
    blank_d  = blank_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    if (new_game_i) begin
      clr_d    = 1'b1;
      winner_d = WIN_NONE;
      blank_d  = 1'b0;
      pend1_d  = '0;
      pend2_d  = '0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          up1_d = ((src == SRC_PEND1) || (src == SRC_NEW1)) &  src_up;
          dn1_d = ((src == SRC_PEND1) || (src == SRC_NEW1)) & ~src_up;
          up2_d = ((src == SRC_PEND2) || (src == SRC_NEW2)) &  src_up;
          dn2_d = ((src == SRC_PEND2) || (src == SRC_NEW2)) & ~src_up;
          // A latched event that has become saturated is discarded; a served one is consumed.
          if ((pend1_q.valid && !pend1_ok) || (src == SRC_PEND1)) pend1_d = '0;
          if ((pend2_q.valid && !pend2_ok) || (src == SRC_PEND2)) pend2_d = '0;
          // Losing new events park in an empty latch, otherwise they are dropped.
          if (new1.valid && !pend1_q.valid && (src != SRC_NEW1)) pend1_d = new1;
          if (new2.valid && !pend2_q.valid && (src != SRC_NEW2)) pend2_d = new2;
        end
        ST_SETTLE: begin
          if (new1.valid && !pend1_q.valid) pend1_d = new1;
          if (new2.valid && !pend2_q.valid) pend2_d = new2;
          if (settle_q && (p1_wins || p2_wins)) begin
            winner_d = p1_wins ? WIN_P1 : WIN_P2;
            blank_d  = 1'b1;
            pend1_d  = '0;
            pend2_d  = '0;
          end
        end
        ST_WON: begin
          if (undo) begin
            dn1_d    = (winner_q == WIN_P1);
            dn2_d    = (winner_q == WIN_P2);
            winner_d = WIN_NONE;
            blank_d  = 1'b0;
          end else if (hold_expired) begin
            clr_d    = 1'b1;
            winner_d = WIN_NONE;
            blank_d  = 1'b0;
            pend1_d  = '0;
            pend2_d  = '0;
          end else if (blink_toggle) begin
            blank_d = ~blank_q;
          end
        end
        ST_CLEAR: begin
          winner_d = WIN_NONE;
          blank_d  = 1'b0;
          pend1_d  = '0;
          pend2_d  = '0;
        end
        default: begin
          winner_d = WIN_NONE;
          blank_d  = 1'b0;
        end
      endcase
    end
  end

  // Output and pending-latch registers.
  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up1_q    <= 1'b0;
      dn1_q    <= 1'b0;
      up2_q    <= 1'b0;
      dn2_q    <= 1'b0;
      clr_q    <= 1'b0;
      winner_q <= WIN_NONE;
      blank_q  <= 1'b0;
      pend1_q  <= '0;
      pend2_q  <= '0;
    end else begin
      up1_q    <= up1_d;
      dn1_q    <= dn1_d;
      up2_q    <= up2_d;
      dn2_q    <= dn2_d;
      clr_q    <= clr_d;
      winner_q <= winner_d;
      blank_q  <= blank_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
    end
  end

  assign up_p1_o     = up1_q;
  assign down_p1_o   = dn1_q;
  assign up_p2_o     = up2_q;
  assign down_p2_o   = dn2_q;
  assign score_clr_o = clr_q;
  assign winner_o    = winner_q;
  assign blank_o     = blank_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: vector table plus multi-cycle sequences.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ng, u1, d1, u2, d2;
  logic [6:0] s1, s2;
  logic       u1o, d1o, u2o, d2o, clro, blanko;
  logic [1:0] wino;
  logic [2:0] sto;
  logic [10:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [2:0] P = 3'd0, S = 3'd1, W = 3'd2, C = 3'd3;

  typedef struct {
    logic [4:0]  ev;   // {new_game, up1, down1, up2, down2}
    logic [6:0]  s1;
    logic [6:0]  s2;
    logic [10:0] exp;  // {u1o,d1o,u2o,d2o, clr, winner[1:0], blank, state[2:0]}
  } vec_t;

  vec_t tbl[$];

  match_controller #(
    .WIN_SCORE  (21),
    .WIN_MARGIN (2),
    .BLINK_MS   (250),
    .HOLD_MS    (10000)
  ) dut (
    .clk_1khz_i  (clk),
    .rst_ni      (rst_n),
    .up_p1_i     (u1),
    .down_p1_i   (d1),
    .up_p2_i     (u2),
    .down_p2_i   (d2),
    .score_p1_i  (s1),
    .score_p2_i  (s2),
    .new_game_i  (ng),
    .up_p1_o     (u1o),
    .down_p1_o   (d1o),
    .up_p2_o     (u2o),
    .down_p2_o   (d2o),
    .score_clr_o (clro),
    .winner_o    (wino),
    .blank_o     (blanko),
    .state_o     (sto)
  );

  always #5 clk = ~clk;

  assign obs = {u1o, d1o, u2o, d2o, clro, wino, blanko, sto};

  function automatic logic [10:0] mk(input logic [3:0] p, input logic c, input logic [1:0] w,
                                     input logic b, input logic [2:0] st);
    return {p, c, w, b, st};
  endfunction

  task automatic add(input logic [4:0] ev, input int unsigned a, input int unsigned b,
                     input logic [3:0] p, input logic c, input logic [1:0] w,
                     input logic bl, input logic [2:0] st);
    vec_t v;
    v.ev  = ev;
    v.s1  = 7'(a);
    v.s2  = 7'(b);
    v.exp = mk(p, c, w, bl, st);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (u1 d1 u2 d2 clr win blank state)", name, act, exp);
    end
  endtask

  task automatic put(input logic [4:0] ev, input int unsigned a, input int unsigned b);
    {ng, u1, d1, u2, d2} = ev;
    s1 = 7'(a);
    s2 = 7'(b);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    put(5'b00000, 20, 19);

    // Vector table: one row per clock edge, state carries from row to row.
    add(5'b00000, 20, 19, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00100,  0, 50, 4'b0000, 0, 2'b00, 0, P);  // down at 0 dropped
    add(5'b00010,  0, 99, 4'b0000, 0, 2'b00, 0, P);  // up at 99 dropped
    add(5'b01100,  5,  5, 4'b1000, 0, 2'b00, 0, S);  // up beats down
    add(5'b00001,  6,  5, 4'b0000, 0, 2'b00, 0, S);  // latched during SETTLE
    add(5'b00000,  6,  5, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00000,  6,  5, 4'b0001, 0, 2'b00, 0, S);  // latched down served
    add(5'b00000,  6,  4, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000,  6,  4, 4'b0000, 0, 2'b00, 0, P);
    add(5'b01010, 10, 10, 4'b1000, 0, 2'b00, 0, S);  // simultaneous ups
    add(5'b00000, 11, 10, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 11, 10, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00000, 11, 10, 4'b0010, 0, 2'b00, 0, S);  // P2 up 3 cycles after P1
    add(5'b00000, 11, 11, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 11, 11, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00000, 11, 11, 4'b0000, 0, 2'b00, 0, P);  // nothing left pending
    add(5'b00010, 21, 20, 4'b0010, 0, 2'b00, 0, S);
    add(5'b00000, 21, 21, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 21, 21, 4'b0000, 0, 2'b00, 0, P);  // 21/21 no winner
    add(5'b01000, 21, 20, 4'b1000, 0, 2'b00, 0, S);
    add(5'b00000, 22, 20, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 22, 20, 4'b0000, 0, 2'b01, 1, W);  // 22/20 P1 wins
    add(5'b01000, 22, 20, 4'b0000, 0, 2'b01, 1, W);  // up dropped in WON
    add(5'b00001, 22, 20, 4'b0000, 0, 2'b01, 1, W);  // loser down dropped
    add(5'b00010, 22, 20, 4'b0000, 0, 2'b01, 1, W);
    add(5'b00100, 22, 20, 4'b0100, 0, 2'b00, 0, S);  // winner undo
    add(5'b00000, 21, 20, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 21, 20, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00001, 21, 20, 4'b0001, 0, 2'b00, 0, S);
    add(5'b11000, 21, 19, 4'b0000, 1, 2'b00, 0, C);  // new game in SETTLE
    add(5'b00000,  0,  0, 4'b0000, 0, 2'b00, 0, P);
    add(5'b11000,  0,  0, 4'b0000, 1, 2'b00, 0, C);  // new game beats up in PLAY
    add(5'b00000,  0,  0, 4'b0000, 0, 2'b00, 0, P);
    add(5'b00010,  2, 21, 4'b0010, 0, 2'b00, 0, S);
    add(5'b00000,  2, 22, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000,  2, 22, 4'b0000, 0, 2'b10, 1, W);  // P2 wins
    add(5'b00100,  2, 22, 4'b0000, 0, 2'b10, 1, W);  // loser down dropped
    add(5'b10000,  2, 22, 4'b0000, 1, 2'b00, 0, C);  // new game in WON
    add(5'b00000,  0,  0, 4'b0000, 0, 2'b00, 0, P);
    add(5'b01000, 98, 97, 4'b1000, 0, 2'b00, 0, S);
    add(5'b00000, 99, 97, 4'b0000, 0, 2'b00, 0, S);
    add(5'b00000, 99, 97, 4'b0000, 0, 2'b01, 1, W);  // 99 >= 97+2 without wrap
    add(5'b10000, 99, 97, 4'b0000, 1, 2'b00, 0, C);
    add(5'b00000,  0,  0, 4'b0000, 0, 2'b00, 0, P);

    #12;
    chk("reset_state", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      put(tbl[i].ev, tbl[i].s1, tbl[i].s2);
      cycle();
      chk($sformatf("row%0d", i), obs, tbl[i].exp);
    end

    // Win at 21/19, blink half-periods and automatic new game after the hold time.
    put(5'b01000, 20, 19);
    cycle();
    chk("win_up_pulse", obs, mk(4'b1000, 0, 2'b00, 0, S));
    put(5'b00000, 21, 19);
    cycle();
    cycle();
    chk("win_enter", obs, mk(4'b0000, 0, 2'b01, 1, W));
    for (int k = 1; k <= 10001; k++) begin
      cycle();
      case (k)
        249:   chk("blink_249",   obs, mk(4'b0000, 0, 2'b01, 1, W));
        250:   chk("blink_250",   obs, mk(4'b0000, 0, 2'b01, 0, W));
        499:   chk("blink_499",   obs, mk(4'b0000, 0, 2'b01, 0, W));
        500:   chk("blink_500",   obs, mk(4'b0000, 0, 2'b01, 1, W));
        9999:  chk("hold_9999",   obs, mk(4'b0000, 0, 2'b01, 0, W));
        10000: chk("hold_clear",  obs, mk(4'b0000, 1, 2'b00, 0, C));
        10001: chk("hold_play",   obs, mk(4'b0000, 0, 2'b00, 0, P));
        default: ;
      endcase
    end

    // Undo from WON, then reset asserted while the undo pulse is high.
    put(5'b01000, 20, 19);
    cycle();
    put(5'b00000, 21, 19);
    cycle();
    cycle();
    chk("undo_won", obs, mk(4'b0000, 0, 2'b01, 1, W));
    cycle();
    cycle();
    put(5'b00100, 21, 19);
    cycle();
    chk("undo_pulse", obs, mk(4'b0100, 0, 2'b00, 0, S));
    put(5'b00000, 20, 19);
    #3 rst_n = 1'b0;
    #1 chk("reset_midpulse", obs, '0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    put(5'b01000, 20, 19);
    cycle();
    chk("first_after_reset", obs, mk(4'b1000, 0, 2'b00, 0, S));
    put(5'b00000, 21, 19);
    cycle();
    cycle();
    chk("rewin", obs, mk(4'b0000, 0, 2'b01, 1, W));

    // Reset during WON clears everything without waiting for a clock.
    for (int k = 0; k < 10; k++) cycle();
    #4 rst_n = 1'b0;
    #1 chk("reset_in_won", obs, '0);
    cycle();
    chk("reset_held", obs, '0);
    #3 rst_n = 1'b1;
    cycle();
    chk("after_release", obs, mk(4'b0000, 0, 2'b00, 0, P));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter WIN_SCORE, default 21: minimum score required to win a game.
REQ-002 Parameter WIN_MARGIN, default 2: minimum lead over the opponent required to win.
REQ-003 Parameter BLINK_MS, default 250: number of cycles per blink half-period in WON.
REQ-004 Parameter HOLD_MS, default 10000: number of cycles in WON before the automatic new game.
REQ-005 clk_1khz_i  in  1  single 1 kHz clock; all state changes on its rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 up_p1_i, down_p1_i, up_p2_i, down_p2_i  in  1 each  single-cycle pulses from the per-player pushbutton processors.
REQ-008 score_p1_i, score_p2_i  in  7 each  registered counter values, 0-99.
REQ-009 new_game_i  in  1  single-cycle request to clear both scores.
REQ-010 up_p1_o, down_p1_o, up_p2_o, down_p2_o  out  1 each  gated single-cycle pulses to the per-player counters.
REQ-011 score_clr_o  out  1  single-cycle clear pulse to both counters.
REQ-012 winner_o  out  2  game result: 00 none, 01 player 1, 10 player 2 (11 never driven).
REQ-013 blank_o  out  1  display blank request; the display path blanks both digits while it is high.
REQ-014 state_o  out  3  current state encoding, for debug.

Function
REQ-015 States SHALL be PLAY, SETTLE, WON and CLEAR; reset enters PLAY.
REQ-016 PLAY: an accepted event SHALL drive the matching output pulse high for exactly one cycle, on the cycle after the input pulse (latency 1), and enter SETTLE.
REQ-017 Arbitration, one accepted event per cycle; P1 has priority over P2; a P2 event that loses arbitration SHALL be latched as pending and served first when PLAY is next entered.
REQ-018 Each player SHALL have a one-deep pending latch; an event arriving while that player's latch is full SHALL be dropped.
REQ-019 If up and down arrive for the same player in the same cycle, up SHALL be kept and down dropped.
REQ-020 Saturation: an up event SHALL be dropped when the player's score is 99; a down event SHALL be dropped when the score is 0; a dropped event produces no output pulse and no state change.
REQ-021 SETTLE SHALL last exactly 2 cycles; during SETTLE, incoming events go to the pending latches.
REQ-022 At the end of SETTLE, P1 wins if score_p1_i >= WIN_SCORE and score_p1_i >= score_p2_i + WIN_MARGIN; the P2 check is symmetric; the comparison SHALL use 8-bit unsigned arithmetic with no overflow.
REQ-023 On a win, the block SHALL set winner_o, clear both pending latches and enter WON; otherwise it returns to PLAY.
REQ-024 WON: blank_o SHALL toggle every BLINK_MS cycles, starting high on entry.
REQ-025 WON: up events from either player and down events from the loser SHALL be dropped.
REQ-026 WON: a down event from the winner SHALL be forwarded as an undo; winner_o clears, blank_o goes low, and the block enters SETTLE.
REQ-027 WON: after HOLD_MS cycles with no undo, the block SHALL enter CLEAR.
REQ-028 new_game_i SHALL take priority over every event in every state and enter CLEAR on the next cycle.
REQ-029 CLEAR SHALL last 1 cycle: score_clr_o high, winner_o = 00, blank_o low, pending latches cleared, timers cleared; next state PLAY.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 With rst_ni low, asynchronously: state PLAY; all pulse outputs and score_clr_o 0; winner_o 00; blank_o 0; pending latches, blink counter and hold counter 0.
REQ-032 Reset asserted mid-pulse SHALL terminate the pulse immediately; the first event is accepted on the first clock edge after rst_ni rises.

Structure
REQ-033 State encoding, winner codes and the 99 score ceiling SHALL live in shared package scoreboard_pkg.
REQ-034 The blink/hold timing SHALL be one sub-module, match_timer (enable, clear, blink toggle, hold-expired flag).

Verification
REQ-035 Scenario: scores 20/19, up_p1_i pulse -> up_p1_o one cycle later; scores 21/19 -> after SETTLE winner_o = 01, blank_o toggles every 250 cycles.
REQ-036 Scenario: scores 21/20, up_p1_i -> 22/20 -> winner 01; a separate 21/21 case -> no winner, return to PLAY.
REQ-037 Scenario: up_p1_i and up_p2_i in the same cycle -> up_p1_o at t+1, up_p2_o exactly 3 cycles later (after SETTLE), no pulse lost.
REQ-038 Scenario: score_p1_i = 0 with down_p1_i -> no pulse; score_p2_i = 99 with up_p2_i -> no pulse; state stays PLAY.
REQ-039 Scenario: in WON (winner 01), down_p1_i -> down_p1_o, winner_o = 00; with no undo, after 10000 cycles -> score_clr_o for 1 cycle, then PLAY.
REQ-040 Scenario: new_game_i during SETTLE, and rst_ni low during WON -> CLEAR then PLAY, or the REQ-031 values asynchronously, respectively.
